axis_slave_fifo: RTL
====================

# axis_slave_fifo

Parametrised AXI4-Stream slave-side FIFO with a first-word-fall-through read port. It is the successor to the original slave FIFO in the crop-video datapath: it accepts pixel beats on the slave interface and presents them to the crop core. Compared with the original, it adds generic width, depth and TUSER width, stored TSTRB, and occupancy and threshold flags. Full, empty and TREADY are exact: no beat is lost, and the full DEPTH is usable. A compile-time packet mode is also available.

## Interface
- TDATA_WIDTH, 32, data width in bits; must be a multiple of 8.
- TUSER_WIDTH, 1, sideband width stored with each beat.
- FIFO_DEPTH, 16, number of beats; power of two, ≥ 4.
- ALMOST_FULL_TH, FIFO_DEPTH-2, almost_full asserts when level ≥ this value.
- ALMOST_EMPTY_TH, 2, almost_empty asserts when level ≤ this value.

Ports (L = $clog2(FIFO_DEPTH)):
- S_AXIS_ACLK  in  1  single clock for all logic.
- S_AXIS_ARESETN  in  1  asynchronous, active-low reset.
- S_AXIS_TVALID  in  1  slave beat valid.
- S_AXIS_TREADY  out  1  slave ready.
- S_AXIS_TDATA  in  TDATA_WIDTH  beat data.
- S_AXIS_TSTRB  in  TDATA_WIDTH/8  byte strobes; stored with the beat.
- S_AXIS_TUSER  in  TUSER_WIDTH  sideband; bit 0 is start-of-frame.
- S_AXIS_TLAST  in  1  end of line/packet.
- rd_en  in  1  consume the head beat.
- valid_out  out  1  head beat present; equals !empty.
- data_out  out  TDATA_WIDTH  head data.
- strb_out  out  TDATA_WIDTH/8  head strobes.
- user_out  out  TUSER_WIDTH  head sideband.
- last_out  out  1  head TLAST.
- level  out  L+1  current occupancy, 0..FIFO_DEPTH.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- rd_err  out  1  one-cycle pulse when rd_en is sampled while empty.

## Operation
- Storage: one memory of FIFO_DEPTH entries, each {TDATA, TSTRB, TUSER, TLAST}.
- Pointers: wr_ptr and rd_ptr are L bits wide and wrap naturally modulo FIFO_DEPTH.
- Count: count register is L+1 bits wide.
- Write: a beat is accepted when S_AXIS_TVALID && S_AXIS_TREADY. The entry is written at wr_ptr, then wr_ptr increments.
- Read: a beat is consumed when rd_en && !empty. rd_ptr increments. data_out, strb_out, user_out and last_out always show entry[rd_ptr].
- Count update: +1 on write only; −1 on read only; unchanged when both occur in the same cycle or when neither occurs.
- Flags, all decoded from registers only (no input-to-output combinational path):
  - full = (count == FIFO_DEPTH)
  - empty = (count == 0)
  - S_AXIS_TREADY = !full, forced low while in reset
  - level = count
- Threshold flags: almost_full = (count ≥ ALMOST_FULL_TH); almost_empty = (count ≤ ALMOST_EMPTY_TH).
- Read while empty is ignored: no pointer or count change, and rd_err pulses.
- Write while full cannot occur, because TREADY is low.

## Timing
- Reset (asynchronous assert, release on an ACLK edge):
  - Pointers and count = 0.
  - empty = 1; full = 0; TREADY = 0.
  - almost_empty = 1; almost_full = 0; rd_err = 0; level = 0.
  - valid_out = 0; data_out, strb_out, user_out, last_out = 0.
  - TREADY = 1 on the first cycle after release.
- Reset asserted mid-transfer discards all stored beats. No partial state survives.
- Write latency: a beat accepted at edge N is visible on data_out with valid_out = 1 after edge N. Head data is readable in the cycle after acceptance.
- Read: rd_en sampled at edge N with !empty retires the head beat. The next beat (or empty) appears after edge N.
- Full boundary: with count = FIFO_DEPTH, a read at edge N makes TREADY = 1 after N. A write is possible at N+1.
- Full with simultaneous read and TVALID: the write is not accepted that cycle.
- Empty with simultaneous write and rd_en: the write is accepted, the read is ignored, and rd_err pulses.
- Throughput: 1 beat/cycle sustained in both directions at any level from 1 to FIFO_DEPTH−1.

## Configuration
- AXIS_FIFO_PACKET_MODE_EN defined:
  - A pkt_cnt register (L+1 bits) tracks stored beats that carry TLAST. It increments on an accepted TLAST beat and decrements on a read of a last_out beat; simultaneous events cancel.
  - Read-side empty = (count == 0) || (pkt_cnt == 0 && !full). A line is released only once its TLAST is stored.
  - When full with no complete packet, the FIFO releases the beats to avoid deadlock.
  - level still reports raw occupancy.
- Undefined: pkt_cnt is absent and empty = (count == 0).

## Test plan
- Reset, then write 0x11..0x14 back-to-back with no reads:
  - level = 4, almost_empty = 0, data_out = 0x11 one cycle after the first acceptance.
  - Read 4 beats: output order 0x11..0x14, then empty = 1 and rd_err = 0.
- Fill 16 beats with rd_en = 0:
  - full = 1 and TREADY = 0 after the 16th acceptance; almost_full set from level 14.
  - TVALID held high for 3 more cycles: no acceptance, level stays 16.
  - One read: TREADY = 1 next cycle.
- Continuous TVALID and rd_en at level 8 for 100 cycles: level stays 8, data order is preserved across pointer wrap, and TSTRB/TUSER/TLAST stay aligned with their data.
- rd_en = 1 while empty with a simultaneous write of 0xAA: rd_err pulses once, level = 1, data_out = 0xAA.
- Write 5 beats, assert ARESETN low mid-stream, release: empty = 1, level = 0, all outputs at reset values, TREADY = 1 after release.
- Packet mode: write 3 beats without TLAST → valid_out = 0; write a 4th beat with TLAST = 1 → valid_out = 1 next cycle.

Source files
------------

// File: rtl/axis_slave_fifo.sv
// axis_slave_fifo
//   AXI4-Stream slave-side FIFO with a first-word-fall-through read port.
//   Each entry stores {TDATA, TSTRB, TUSER, TLAST}. The full FIFO_DEPTH is
//   usable. All status flags are decoded from registers only.
//
// Optional feature (compile-time macro AXIS_FIFO_PACKET_MODE_EN):
//   When this macro is defined, the read side reports empty until a complete
//   packet (a beat with TLAST) is stored. A full FIFO with no complete packet
//   still releases its beats so that the FIFO cannot deadlock.
//
// Ports:
//   S_AXIS_ACLK     clock for all logic
//   S_AXIS_ARESETN  asynchronous active-low reset
//   S_AXIS_T*       AXI4-Stream slave (TVALID/TREADY/TDATA/TSTRB/TUSER/TLAST)
//   rd_en           consumes the head beat
//   valid_out       head beat present (equals !empty)
//   data_out/strb_out/user_out/last_out  head entry fields
//   level           occupancy, 0..FIFO_DEPTH
//   full/empty/almost_full/almost_empty  status flags
//   rd_err          one-cycle pulse when rd_en is sampled while empty
module axis_slave_fifo #(
   parameter int unsigned TDATA_WIDTH     = 32,
   parameter int unsigned TUSER_WIDTH     = 1,
   parameter int unsigned FIFO_DEPTH      = 16,
   parameter int unsigned ALMOST_FULL_TH  = FIFO_DEPTH - 2,
   parameter int unsigned ALMOST_EMPTY_TH = 2,
   localparam int unsigned L              = $clog2(FIFO_DEPTH),
   localparam int unsigned STRB_W         = TDATA_WIDTH / 8
) (
   input  logic                   S_AXIS_ACLK,
   input  logic                   S_AXIS_ARESETN,
   input  logic                   S_AXIS_TVALID,
   output logic                   S_AXIS_TREADY,
   input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic [STRB_W-1:0]      S_AXIS_TSTRB,
   input  logic [TUSER_WIDTH-1:0] S_AXIS_TUSER,
   input  logic                   S_AXIS_TLAST,
   input  logic                   rd_en,
   output logic                   valid_out,
   output logic [TDATA_WIDTH-1:0] data_out,
   output logic [STRB_W-1:0]      strb_out,
   output logic [TUSER_WIDTH-1:0] user_out,
   output logic                   last_out,
   output logic [L:0]             level,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic                   rd_err
);

   localparam int unsigned EW = TDATA_WIDTH + STRB_W + TUSER_WIDTH + 1;

   typedef logic [L:0]   cnt_t;
   typedef logic [L-1:0] ptr_t;

   localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);
   localparam cnt_t AF_C    = cnt_t'(ALMOST_FULL_TH);
   localparam cnt_t AE_C    = cnt_t'(ALMOST_EMPTY_TH);

   logic [EW-1:0] mem_q [FIFO_DEPTH];
   ptr_t          wr_ptr_q, wr_ptr_d;
   ptr_t          rd_ptr_q, rd_ptr_d;
   cnt_t          count_q,  count_d;
   logic          rd_err_q, rd_err_d;
   logic          rst_done_q;
   logic          wr_fire, rd_fire;

   // Head entry is always visible (first-word fall-through).
   assign {data_out, strb_out, user_out, last_out} = mem_q[rd_ptr_q];

   assign full          = (count_q == DEPTH_C);
   // rst_done_q keeps TREADY low while in reset and until the first edge after release.
   assign S_AXIS_TREADY = rst_done_q && !full;
   assign level         = count_q;
   assign almost_full   = (count_q >= AF_C);
   assign almost_empty  = (count_q <= AE_C);
   assign valid_out     = !empty;
   assign rd_err        = rd_err_q;

   assign wr_fire = S_AXIS_TVALID && S_AXIS_TREADY;
   assign rd_fire = rd_en && !empty;

`ifdef AXIS_FIFO_PACKET_MODE_EN
   cnt_t pkt_cnt_q, pkt_cnt_d;

   // Reads are held off until a TLAST beat is stored; a full FIFO is always
   // drainable so a packet longer than the FIFO cannot stall the stream.
   assign empty = (count_q == '0) || ((pkt_cnt_q == '0) && !full);

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      unique case ({wr_fire && S_AXIS_TLAST, rd_fire && last_out})
         2'b10:   pkt_cnt_d = pkt_cnt_q + cnt_t'(1);
         2'b01:   pkt_cnt_d = pkt_cnt_q - cnt_t'(1);
         default: pkt_cnt_d = pkt_cnt_q;
      endcase
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) pkt_cnt_q <= '0;
      else                 pkt_cnt_q <= pkt_cnt_d;
   end
`else
   assign empty = (count_q == '0);
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      rd_err_d = rd_en && empty;
      if (wr_fire) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      unique case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_err_q   <= 1'b0;
         rst_done_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_err_q   <= rd_err_d;
         rst_done_q <= 1'b1;
      end
   end

   // Storage is cleared on reset so the head outputs read zero afterwards.
   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_fire) begin
         mem_q[wr_ptr_q] <= {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
      end
   end

endmodule
